key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/key_expansion.sv | 195 +++++++++++++++++++
 tb/tb_key_expansion.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// AES key schedule generator (AES-128/192/256). It writes one expanded word per clock.
// Bit order is MSB-first: word w[i] is keyExp[1919-32*i -: 32], and the first key byte is key[255:248].

module sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);
    // Forward S-box table. The entry for byte v sits at bits [8*(255-v)+7 -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign result = SBOX_TABLE[{~data, 3'b111} -: 8];
endmodule

module key_expansion (
    input  logic          clk,
    input  logic          rst,
    input  logic          enableKeyExp,
    input  logic [255:0]  key,
    input  logic [4:0]    numRounds,
    output logic [1919:0] keyExp,
    output logic          keyExpDone,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} stateT;

    stateT       stateReg, stateNext;
    logic        enableReg, armedReg;
    logic        startReq, loadKey, stepWord, lastWord, modLast;
    logic [3:0]  nkReg, nkNew;
    logic [5:0]  lastIdxReg, lastIdxNew;
    logic [5:0]  idxReg;
    logic [2:0]  modReg;
    logic [2:0]  topIdx;
    logic [7:0]  rconReg, rconNext;
    logic [255:0] keyMask;
    logic [31:0] winReg  [8];
    logic [31:0] keyWord [8];
    logic [31:0] loadWin [8];
    logic [31:0] prevWord, oldWord, rotWord, subIn, subOut, temp, newWord;

    // Decode the round count into key length and index of the final word.
    always_comb begin
        nkNew      = 4'd4;
        lastIdxNew = 6'd43;
        keyMask    = {{128{1'b1}}, 128'h0};
        if (numRounds == 5'd15) begin
            nkNew      = 4'd8;
            lastIdxNew = 6'd59;
            keyMask    = '1;
        end else if (numRounds == 5'd13) begin
            nkNew      = 4'd6;
            lastIdxNew = 6'd51;
            keyMask    = {{192{1'b1}}, 64'h0};
        end
    end

    assign topIdx = 3'(nkNew - 4'd1);

    // The window keeps the newest word at winReg[0], so w[i-1] is winReg[0] and w[i-Nk] is winReg[Nk-1].
    for (genvar gi = 0; gi < 8; gi++) begin : genWords
        assign keyWord[gi] = key[255-32*gi -: 32];
        assign loadWin[gi] = (3'(gi) <= topIdx) ? keyWord[topIdx - 3'(gi)] : 32'h0;
    end

    // armedReg makes a start wait for a fresh rising edge when enable is already high as reset ends.
    assign startReq = enableKeyExp & ~enableReg & armedReg & (stateReg != EXPAND);
    assign lastWord = (idxReg == lastIdxReg);
    assign modLast  = (modReg == 3'(nkReg - 4'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enableReg <= 1'b0;
            armedReg  <= 1'b0;
        end else begin
            enableReg <= enableKeyExp;
            if (!enableKeyExp)
                armedReg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stateReg <= IDLE;
        else
            stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE, DONE: if (startReq) stateNext = EXPAND;
            EXPAND:     if (lastWord) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        keyExpDone = 1'b0;
        loadKey    = 1'b0;
        stepWord   = 1'b0;
        case (stateReg)
            IDLE:   loadKey = startReq;
            EXPAND: begin
                busy     = 1'b1;
                stepWord = 1'b1;
            end
            DONE:   begin
                keyExpDone = 1'b1;
                loadKey    = startReq;
            end
            default: ;
        endcase
    end

    assign prevWord = winReg[0];
    assign rotWord  = {prevWord[23:0], prevWord[31:24]};
    assign subIn    = (modReg == 3'd0) ? rotWord : prevWord;

    for (genvar gi = 0; gi < 4; gi++) begin : genSub
        sbox uSbox (
            .data   (subIn[8*gi +: 8]),
            .result (subOut[8*gi +: 8])
        );
    end

    always_comb begin
        case (nkReg)
            4'd8:    oldWord = winReg[7];
            4'd6:    oldWord = winReg[5];
            default: oldWord = winReg[3];
        endcase
    end

    always_comb begin
        temp = prevWord;
        if (modReg == 3'd0)
            temp = subOut ^ {rconReg, 24'h0};
        else if (nkReg == 4'd8 && modReg == 3'd4)
            temp = subOut;
    end

    assign newWord  = oldWord ^ temp;
    assign rconNext = {rconReg[6:0], 1'b0} ^ (rconReg[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyExp     <= '0;
            nkReg      <= 4'd4;
            lastIdxReg <= 6'd43;
            idxReg     <= 6'd0;
            modReg     <= 3'd0;
            rconReg    <= 8'h01;
            for (int k = 0; k < 8; k++)
                winReg[k] <= 32'h0;
        end else if (loadKey) begin
            keyExp     <= {key & keyMask, 1664'h0};
            nkReg      <= nkNew;
            lastIdxReg <= lastIdxNew;
            idxReg     <= {2'b00, nkNew};
            modReg     <= 3'd0;
            rconReg    <= 8'h01;
            for (int k = 0; k < 8; k++)
                winReg[k] <= loadWin[k];
        end else if (stepWord) begin
            for (int j = 0; j < 60; j++)
                if (idxReg == 6'(j))
                    keyExp[1919-32*j -: 32] <= newWord;
            winReg[0] <= newWord;
            for (int k = 1; k < 8; k++)
                winReg[k] <= winReg[k-1];
            idxReg <= idxReg + 6'd1;
            modReg <= modLast ? 3'd0 : modReg + 3'd1;
            if (modReg == 3'd0)
                rconReg <= rconNext;
        end
    end
endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 vectors plus random keys.
// The reference model uses textbook AES key expansion with an S-box computed from GF(2^8) arithmetic.

module tb_key_expansion;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enableKeyExp;
    logic [255:0]  key;
    logic [4:0]    numRounds;
    logic [1919:0] keyExp;
    logic          keyExpDone;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sboxTab [256];

    key_expansion dut (
        .clk          (clk),
        .rst          (rst),
        .enableKeyExp (enableKeyExp),
        .key          (key),
        .numRounds    (numRounds),
        .keyExp       (keyExp),
        .keyExpDone   (keyExpDone),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1919:0] got, input logic [1919:0] exp);
        int firstBad;
        checks++;
        if (got !== exp) begin
            errors++;
            firstBad = 0;
            for (int j = 59; j >= 0; j--)
                if (got[1919-32*j -: 32] !== exp[1919-32*j -: 32])
                    firstBad = j;
            $display("FAIL %s: word %0d got %h expected %h", tag, firstBad,
                     got[1919-32*firstBad -: 32], exp[1919-32*firstBad -: 32]);
        end else begin
            $display("ok   %s", tag);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++)
                inv = gmul(inv, 8'(x));
            sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWordRef(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    function automatic int nkOf(input logic [4:0] nr);
        return (nr == 5'd15) ? 8 : (nr == 5'd13) ? 6 : 4;
    endfunction

    function automatic int refLatency(input logic [4:0] nr);
        int nk;
        nk = nkOf(nr);
        return 4 * (nk + 7) - nk;
    endfunction

    function automatic logic [1919:0] expandRef(input logic [255:0] k, input logic [4:0] nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int nk, total;
        nk    = nkOf(nr);
        total = 4 * (nk + 7);
        rc    = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWordRef(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [31:0] wordOf(input logic [1919:0] v, input int i);
        return v[1919-32*i -: 32];
    endfunction

    task automatic pulseStart(input logic [255:0] k, input logic [4:0] nr);
        @(negedge clk);
        enableKeyExp = 1'b0;
        @(negedge clk);
        key          = k;
        numRounds    = nr;
        enableKeyExp = 1'b1;
        @(posedge clk);
    endtask

    task automatic runAndCheck(input string tag, input logic [255:0] k, input logic [4:0] nr,
                               input bit scramble, input bit reEnable, input int expLat);
        logic [1919:0] exp;
        int cyc;
        exp = expandRef(k, nr);
        pulseStart(k, nr);
        #1;
        check({tag, "_busyAtStart"}, busy, 1);
        check({tag, "_doneCleared"}, keyExpDone, 0);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (scramble && cyc == 3) begin
                key       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                numRounds = 5'($urandom_range(0, 31));
            end
            if (reEnable && cyc == 5) enableKeyExp = 1'b0;
            if (reEnable && cyc == 7) enableKeyExp = 1'b1;
        end while (!keyExpDone && cyc < 200);
        check({tag, "_latency"}, 1920'(cyc), 1920'(expLat));
        check({tag, "_keyExp"}, keyExp, exp);
        check({tag, "_busyAtDone"}, busy, 0);
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_holdKeyExp"}, keyExp, exp);
        check({tag, "_holdDone"}, keyExpDone, 1);
        check({tag, "_holdBusy"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] nr;
        buildSbox();
        rst          = 1'b0;
        enableKeyExp = 1'b1;
        key          = '0;
        numRounds    = 5'd11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_keyExp", keyExp, '0);
        check("rst_done", keyExpDone, 0);
        check("rst_busy", busy, 0);

        // Enable already high as reset ends: no start may occur.
        @(negedge clk) rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("heldEnable_busy", busy, 0);
        check("heldEnable_done", keyExpDone, 0);

        runAndCheck("aes128", K128, 5'd11, 1'b0, 1'b0, 40);
        check("aes128_w4", wordOf(keyExp, 4), 32'ha0fafe17);
        check("aes128_w43", wordOf(keyExp, 43), 32'hb6630ca6);
        check("aes128_tailZero", keyExp[511:0], '0);

        runAndCheck("aes128_reEnable", K128, 5'd11, 1'b0, 1'b1, 40);
        check("aes128_reEnable_w43", wordOf(keyExp, 43), 32'hb6630ca6);

        runAndCheck("aes192", K192, 5'd13, 1'b0, 1'b0, 46);
        check("aes192_w6", wordOf(keyExp, 6), 32'hfe0c91f7);
        check("aes192_w51", wordOf(keyExp, 51), 32'h01002202);

        runAndCheck("aes256", K256, 5'd15, 1'b0, 1'b0, 52);
        check("aes256_w8", wordOf(keyExp, 8), 32'h9ba35411);
        check("aes256_w12", wordOf(keyExp, 12), 32'ha8b09c1a);
        check("aes256_w59", wordOf(keyExp, 59), 32'h706c631e);

        // Reset pulse in the middle of an AES-256 expansion.
        pulseStart(K256, 5'd15);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midRst_keyExp", keyExp, '0);
        check("midRst_done", keyExpDone, 0);
        check("midRst_busy", busy, 0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("afterRst_idle", busy, 0);
        runAndCheck("aes128_afterRst", K128, 5'd11, 1'b0, 1'b0, 40);
        check("aes128_afterRst_w43", wordOf(keyExp, 43), 32'hb6630ca6);

        runAndCheck("nr7", K128, 5'd7, 1'b0, 1'b0, 40);
        check("nr7_sameAsAes128", keyExp, expandRef(K128, 5'd11));
        check("nr7_w4", wordOf(keyExp, 4), 32'ha0fafe17);

        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(0, 3))
                0:       nr = 5'd11;
                1:       nr = 5'd13;
                2:       nr = 5'd15;
                default: nr = 5'($urandom_range(0, 31));
            endcase
            runAndCheck($sformatf("rand%0d_nr%0d", r, nr),
                        {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                        nr, 1'b1, 1'b0, refLatency(nr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
